// File: rtl/match_judge.sv
// rtl/match_judge.sv - pattern-matching game judge with per-level countdown timer
// A round plays lvl-dependent symbols from an external pattern ROM against key presses.
module match_judge #(
    parameter int TICK_DIV = 50000000,
    parameter int TICK_W   = 26
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       start,
    input  logic       player_sel,
    input  logic [3:0] user_id,
    input  logic [1:0] lvl_inp,
    input  logic       key_valid,
    input  logic [3:0] key_val,
    output logic [4:0] pat_addr,
    input  logic [3:0] pat_data,
    output logic       player,
    output logic [3:0] internalid,
    output logic [1:0] lvl_out,
    output logic       win,
    output logic       timeout,
    output logic       fail,
    output logic       busy,
    output logic [3:0] time_left
);

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        PLAY = 3'd1,
        WIN  = 3'd2,
        LOSE = 3'd3,
        TOUT = 3'd4
    } state_t;

    localparam logic [TICK_W-1:0] DIV_MAX = TICK_W'(TICK_DIV - 1);

    state_t            state_q, state_d;
    logic [2:0]        idx_q, idx_d;
    logic [TICK_W-1:0] div_q, div_d;
    logic [3:0]        time_q, time_d;
    logic              player_q, player_d;
    logic [3:0]        id_q, id_d;
    logic [1:0]        lvl_q, lvl_d;

    logic              tick;
    logic [2:0]        last_idx;

    assign tick     = (div_q == DIV_MAX);
    // N-1 = 1 + 2*lvl, so the last index is just {lvl, 1}
    assign last_idx = {lvl_q, 1'b1};

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= IDLE;
            idx_q    <= '0;
            div_q    <= '0;
            time_q   <= '0;
            player_q <= 1'b0;
            id_q     <= '0;
            lvl_q    <= '0;
        end else begin
            state_q  <= state_d;
            idx_q    <= idx_d;
            div_q    <= div_d;
            time_q   <= time_d;
            player_q <= player_d;
            id_q     <= id_d;
            lvl_q    <= lvl_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        idx_d    = idx_q;
        div_d    = div_q;
        time_d   = time_q;
        player_d = player_q;
        id_d     = id_q;
        lvl_d    = lvl_q;

        unique case (state_q)
            IDLE: begin
                if (start) begin
                    player_d = player_sel;
                    id_d     = user_id;
                    lvl_d    = lvl_inp;
                    idx_d    = '0;
                    div_d    = '0;
                    time_d   = 4'd12 - {1'b0, lvl_inp, 1'b0};
                    state_d  = PLAY;
                end
            end
            PLAY: begin
                div_d = tick ? '0 : div_q + 1'b1;
                // A key press in a tick cycle wins over the tick and suppresses the decrement
                if (key_valid) begin
                    if (key_val == pat_data) begin
                        if (idx_q == last_idx) begin
                            state_d = WIN;
                        end else begin
                            idx_d = idx_q + 1'b1;
                        end
                    end else begin
                        state_d = LOSE;
                    end
                end else if (tick) begin
                    time_d = time_q - 1'b1;
                    if (time_q == 4'd1) begin
                        state_d = TOUT;
                    end
                end
            end
            WIN, LOSE, TOUT: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign pat_addr   = {lvl_q, idx_q};
    assign player     = player_q;
    assign internalid = id_q;
    assign lvl_out    = lvl_q;
    assign win        = (state_q == WIN);
    assign fail       = (state_q == LOSE);
    assign timeout    = (state_q == TOUT);
    assign busy       = (state_q == PLAY);
    assign time_left  = time_q;

endmodule

// File: tb/tb_match_judge.sv
// tb/tb_match_judge.sv - directed self-checking bench for match_judge
module tb_match_judge;

    logic       clk = 1'b0;
    logic       reset;
    logic       start;
    logic       player_sel;
    logic [3:0] user_id;
    logic [1:0] lvl_inp;
    logic       key_valid;
    logic [3:0] key_val;
    logic [4:0] pat_addr;
    logic [3:0] pat_data;
    logic       player;
    logic [3:0] internalid;
    logic [1:0] lvl_out;
    logic       win;
    logic       timeout;
    logic       fail;
    logic       busy;
    logic [3:0] time_left;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    // Pattern ROM stand-in
    assign pat_data = pat_addr[3:0] ^ 4'hA;

    match_judge #(.TICK_DIV(4), .TICK_W(26)) dut (
        .clk        (clk),
        .reset      (reset),
        .start      (start),
        .player_sel (player_sel),
        .user_id    (user_id),
        .lvl_inp    (lvl_inp),
        .key_valid  (key_valid),
        .key_val    (key_val),
        .pat_addr   (pat_addr),
        .pat_data   (pat_data),
        .player     (player),
        .internalid (internalid),
        .lvl_out    (lvl_out),
        .win        (win),
        .timeout    (timeout),
        .fail       (fail),
        .busy       (busy),
        .time_left  (time_left)
    );

    function automatic logic [3:0] sym(input logic [1:0] lvl, input logic [2:0] idx);
        return {lvl[0], idx} ^ 4'hA;
    endfunction

    task automatic cyc();
        @(posedge clk);
        #1;
        start     = 1'b0;
        key_valid = 1'b0;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    initial begin
        reset = 1'b1; start = 1'b0; player_sel = 1'b0; user_id = 4'h0;
        lvl_inp = 2'd0; key_valid = 1'b0; key_val = 4'h0;
        cyc();
        cyc();
        check("rst_busy", busy, 1'b0);
        check("rst_time", time_left, 4'd0);
        check("rst_id", internalid, 4'h0);
        check("rst_pulses", {win, fail, timeout}, 3'b000);
        reset = 1'b0;

        // key in IDLE is ignored
        key_valid = 1'b1; key_val = 4'h3;
        cyc();
        check("idle_key_busy", busy, 1'b0);
        cyc();
        check("idle_key_fail", fail, 1'b0);

        // win, lvl 0
        start = 1'b1; player_sel = 1'b1; user_id = 4'h9; lvl_inp = 2'd0;
        cyc();
        check("w_busy", busy, 1'b1);
        check("w_time", time_left, 4'd12);
        check("w_id", internalid, 4'h9);
        check("w_player", player, 1'b1);
        check("w_addr0", pat_addr, 5'd0);
        key_valid = 1'b1; key_val = sym(2'd0, 3'd0);
        cyc();
        check("w_addr1", pat_addr, 5'd1);
        check("w_mid_win", win, 1'b0);
        cyc();
        key_valid = 1'b1; key_val = sym(2'd0, 3'd1);
        cyc();
        check("w_pulses", {win, fail, timeout, busy}, 4'b1000);
        check("w_id_hold", internalid, 4'h9);
        cyc();
        check("w_win_end", win, 1'b0);
        check("w_time_hold", time_left, 4'd12);

        // wrong key, lvl 1
        start = 1'b1; player_sel = 1'b0; user_id = 4'h3; lvl_inp = 2'd1;
        cyc();
        check("l_time", time_left, 4'd10);
        check("l_addr0", pat_addr, 5'd8);
        key_valid = 1'b1; key_val = sym(2'd1, 3'd0);
        cyc();
        check("l_addr1", pat_addr, 5'd9);
        key_valid = 1'b1; key_val = sym(2'd1, 3'd1) ^ 4'h1;
        cyc();
        check("l_pulses", {win, fail, timeout, busy}, 4'b0100);
        check("l_idx_hold", pat_addr, 5'd9);
        cyc();
        check("l_fail_end", fail, 1'b0);

        // timeout, lvl 3
        start = 1'b1; lvl_inp = 2'd3; user_id = 4'h7;
        cyc();
        check("t_time6", time_left, 4'd6);
        for (int k = 1; k <= 5; k++) begin
            repeat (4) cyc();
            check($sformatf("t_time_step%0d", k), time_left, 4'(6 - k));
        end
        repeat (3) cyc();
        check("t_before", {timeout, busy}, 2'b01);
        cyc();
        check("t_pulses", {win, fail, timeout, busy}, 4'b0010);
        check("t_time0", time_left, 4'd0);
        cyc();
        check("t_end", timeout, 1'b0);

        // tie: final key on the expiring tick, lvl 0
        start = 1'b1; lvl_inp = 2'd0; user_id = 4'h4;
        cyc();
        key_valid = 1'b1; key_val = sym(2'd0, 3'd0);
        cyc();
        repeat (46) cyc();
        check("tie_time1", time_left, 4'd1);
        check("tie_busy", busy, 1'b1);
        key_valid = 1'b1; key_val = sym(2'd0, 3'd1);
        cyc();
        check("tie_pulses", {win, fail, timeout}, 3'b100);
        check("tie_no_dec", time_left, 4'd1);
        cyc();
        check("tie_after", {win, timeout}, 2'b00);

        // control: start during PLAY ignored, reset aborts round
        start = 1'b1; lvl_inp = 2'd2; user_id = 4'h5; player_sel = 1'b1;
        cyc();
        start = 1'b1; lvl_inp = 2'd0; user_id = 4'hC; player_sel = 1'b0;
        cyc();
        check("c_id", internalid, 4'h5);
        check("c_lvl", lvl_out, 2'd2);
        check("c_addr", pat_addr, 5'd16);
        reset = 1'b1; key_valid = 1'b1; key_val = sym(2'd2, 3'd0) ^ 4'h2; start = 1'b1;
        cyc();
        check("c_rst_outs", {busy, win, fail, timeout, player}, 5'b00000);
        check("c_rst_regs", {internalid, lvl_out, time_left}, 10'd0);
        reset = 1'b0;
        cyc();
        check("c_no_pulse", {win, fail, timeout, busy}, 4'b0000);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/match_judge.md
MATCH_JUDGE -- requirements
Module: match_judge

Interface
REQ-001 The block SHALL have parameter TICK_DIV, default 50000000: clocks per timer tick (one second at 50 MHz); the bench overrides it to 4.
REQ-002 The block SHALL have parameter TICK_W, default 26: width of the tick divider counter.
REQ-003 The block SHALL have port clk, input, 1 bit: the single clock; all logic is on the rising edge.
REQ-004 The block SHALL have port reset, input, 1 bit: synchronous, active-high reset.
REQ-005 The block SHALL have port start, input, 1 bit: single-cycle request to begin a round.
REQ-006 The block SHALL have port player_sel, input, 1 bit: selects the player for the round.
REQ-007 The block SHALL have port user_id, input, 4 bits: the player's identifier.
REQ-008 The block SHALL have port lvl_inp, input, 2 bits: difficulty level.
REQ-009 The block SHALL have port key_valid, input, 1 bit: single-cycle strobe, one per key press.
REQ-010 The block SHALL have port key_val, input, 4 bits: the pressed symbol, qualified by key_valid.
REQ-011 The block SHALL have port pat_addr, output, 5 bits: pattern ROM address {lvl_r, idx[2:0]}.
REQ-012 The block SHALL have port pat_data, input, 4 bits: expected symbol, combinationally valid for the current pat_addr.
REQ-013 The block SHALL have port player, output, 1 bit: latched player_sel.
REQ-014 The block SHALL have port internalid, output, 4 bits: latched user_id.
REQ-015 The block SHALL have port lvl_out, output, 2 bits: latched lvl_inp.
REQ-016 The block SHALL have port win, output, 1 bit: single-cycle pulse when the pattern is completed.
REQ-017 The block SHALL have port timeout, output, 1 bit: single-cycle pulse when the timer expires.
REQ-018 The block SHALL have port fail, output, 1 bit: single-cycle pulse on a wrong key.
REQ-019 The block SHALL have port busy, output, 1 bit: high while a round is in progress.
REQ-020 The block SHALL have port time_left, output, 4 bits: whole ticks remaining.

Function
REQ-021 The FSM SHALL have states IDLE, PLAY, WIN, LOSE and TOUT; WIN, LOSE and TOUT each last exactly one cycle, then return to IDLE.
REQ-022 In IDLE, start=1 SHALL latch player_sel, user_id and lvl_inp into player, internalid and lvl_r.
REQ-023 In IDLE, start=1 SHALL also clear idx to 0, load time_left = 12 - 2*lvl (12/10/8/6), clear the divider, and enter PLAY on the next cycle.
REQ-024 Pattern length SHALL be N = 2 + 2*lvl_r (2/4/6/8 symbols); idx is 3 bits.
REQ-025 In PLAY, on key_valid with key_val == pat_data: if idx == N-1, go to WIN; otherwise idx increments by 1.
REQ-026 In PLAY, on key_valid with key_val != pat_data, go to LOSE; idx is unchanged.
REQ-027 In PLAY, the divider SHALL count 0..TICK_DIV-1 and wrap; each wrap is one tick and decrements time_left.
REQ-028 A tick that takes time_left from 1 to 0 SHALL go to TOUT.
REQ-029 In the same cycle as a tick, key_valid SHALL have priority: a correct final key gives WIN, a wrong key gives LOSE, and time_left is not decremented that cycle.
REQ-030 win SHALL equal (state==WIN), fail SHALL equal (state==LOSE) and timeout SHALL equal (state==TOUT); at most one of the three is high in any cycle.
REQ-031 busy SHALL equal (state==PLAY).
REQ-032 start while not in IDLE SHALL be ignored.
REQ-033 key_valid outside PLAY SHALL be ignored.
REQ-034 player, internalid and lvl_out SHALL hold their values until the next accepted start, so they remain valid during the result pulse.
REQ-035 time_left SHALL hold its final value in IDLE.
REQ-036 Latency SHALL be: result pulse is high in the cycle after the deciding key or tick edge.

Reset
REQ-037 reset=1 at a clock edge SHALL force state=IDLE, idx=0, divider=0, time_left=0, player=0, internalid=0, lvl_out=0, and win=fail=timeout=busy=0.
REQ-038 reset SHALL override start, key_valid and ticks in the same cycle.
REQ-039 reset asserted mid-round SHALL abort the round with no result pulse.

Verification
REQ-040 Win scenario: reset, lvl=0, start, correct keys at cycles 3 and 6 -> win pulse 1 cycle after the second key; internalid = user_id; fail and timeout stay 0.
REQ-041 Wrong-key scenario: lvl=1, first key correct, second key wrong -> fail pulse only; idx stays 1; busy drops.
REQ-042 Timeout scenario: TICK_DIV=4, lvl=3, no keys -> time_left steps 6..1; timeout pulse 24 clocks after PLAY entry; time_left=0.
REQ-043 Tie scenario: lvl=0, final correct key in the same cycle as the expiring tick -> win, not timeout.
REQ-044 Control scenario: start asserted during PLAY does not change internalid; reset mid-PLAY -> IDLE, all outputs 0, and no pulse on the following cycle.
